// File: rtl/axi2apb_pkg.sv
// Shared definitions for the AXI-to-APB bridge: FSM state encoding, command
// payload field offsets and response layout.
package axi2apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Command payload is {id, addr, data} with data in the LSBs.
    localparam int DATA_LSB = 0;
    localparam int ERR_BIT  = 0;

    function automatic int addr_lsb(input int data_w);
        return DATA_LSB + data_w;
    endfunction

    function automatic int id_lsb(input int addr_w, input int data_w);
        return DATA_LSB + data_w + addr_w;
    endfunction

    function automatic int rsp_w(input int id_num);
        return id_num + 1;
    endfunction

    // Offsets for the default bridge configuration (ID 4, ADDR 12, DATA 32).
    localparam int ADDR_LSB = addr_lsb(32);
    localparam int ID_LSB   = id_lsb(12, 32);
    localparam int RSP_W    = rsp_w(4);

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter; flags expiry on the TIMEOUT-th
// cycle without PREADY. TIMEOUT=0 never expires.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/apb_master_intf.sv
// APB3 write requester: pops {id, addr, data} commands, runs SETUP/ACCESS
// with a wait-state timeout, and returns {id, err} on a valid/ready channel.
module apb_master_intf
    import axi2apb_pkg::*;
#(
    parameter int ID_NUM  = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                        ACLK_i,
    input  logic                        ARESETn_i,
    input  logic                        fifo_rvld_i,
    output logic                        fifo_rrdy_o,
    input  logic [ID_NUM+ADDR_W+DATA_W-1:0] fifo_rpayload_i,
    output logic                        PSEL_o,
    output logic                        PENABLE_o,
    output logic                        PWRITE_o,
    output logic [ADDR_W-1:0]           PADDR_o,
    output logic [DATA_W-1:0]           PWDATA_o,
    input  logic                        PREADY_i,
    input  logic                        PSLVERR_i,
    output logic                        rsp_vld_o,
    input  logic                        rsp_rdy_i,
    output logic [ID_NUM:0]             rsp_payload_o
);

    localparam int A_LSB     = addr_lsb(DATA_W);
    localparam int I_LSB     = id_lsb(ADDR_W, DATA_W);
    localparam int R_W       = rsp_w(ID_NUM);
    localparam int BYTE_BITS = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << BYTE_BITS) - 1);

    apb_state_e        state_q, state_d;
    logic [ID_NUM-1:0] id_q, id_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic [R_W-1:0]    rsp_payload_q, rsp_payload_d;
    logic              pop;
    logic              timer_clr;
    logic              timer_inc;
    logic              timer_expired;

    // Gated by reset so the FIFO is never popped while the bridge is held in reset.
    assign fifo_rrdy_o = ARESETn_i & ((state_q == IDLE) | ((state_q == RESP) & rsp_rdy_i));
    assign pop         = fifo_rvld_i & fifo_rrdy_o;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (ACLK_i),
        .rst_n     (ARESETn_i),
        .clr_i     (timer_clr),
        .inc_i     (timer_inc),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_payload_d = rsp_payload_q;
        timer_clr     = 1'b0;
        timer_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) state_d = SETUP;
            end
            SETUP: begin
                timer_clr = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A real PREADY beats a timeout firing in the same cycle.
                if (PREADY_i) begin
                    state_d       = RESP;
                    rsp_payload_d = {id_q, PSLVERR_i};
                end else if (timer_expired) begin
                    state_d       = RESP;
                    rsp_payload_d = {id_q, 1'b1};
                end else begin
                    timer_inc = 1'b1;
                end
            end
            RESP: begin
                if (rsp_rdy_i) state_d = fifo_rvld_i ? SETUP : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            id_d     = fifo_rpayload_i[I_LSB +: ID_NUM];
            paddr_d  = fifo_rpayload_i[A_LSB +: ADDR_W] & ALIGN_MASK;
            pwdata_d = fifo_rpayload_i[DATA_LSB +: DATA_W];
        end

        // Outputs are registered from the next state so they line up with it.
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        pwrite_d  = psel_d;
        rsp_vld_d = (state_d == RESP);
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            id_q          <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            rsp_vld_q     <= 1'b0;
            rsp_payload_q <= '0;
        end else begin
            id_q          <= id_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_payload_q <= rsp_payload_d;
        end
    end

    assign PSEL_o        = psel_q;
    assign PENABLE_o     = penable_q;
    assign PWRITE_o      = pwrite_q;
    assign PADDR_o       = paddr_q;
    assign PWDATA_o      = pwdata_q;
    assign rsp_vld_o     = rsp_vld_q;
    assign rsp_payload_o = rsp_payload_q;

endmodule

// File: tb/tb_apb_master_intf.sv
// Directed bench for apb_master_intf: zero-wait write, wait states with error,
// timeout and its PREADY tie-break, back-to-back with backpressure, reset abort.
module tb_apb_master_intf;

    logic        ACLK_i = 1'b0;
    logic        ARESETn_i;
    logic        fifo_rvld_i;
    logic        fifo_rrdy_o;
    logic [47:0] fifo_rpayload_i;
    logic        PSEL_o;
    logic        PENABLE_o;
    logic        PWRITE_o;
    logic [11:0] PADDR_o;
    logic [31:0] PWDATA_o;
    logic        PREADY_i;
    logic        PSLVERR_i;
    logic        rsp_vld_o;
    logic        rsp_rdy_i;
    logic [4:0]  rsp_payload_o;

    int errors = 0;
    int checks = 0;

    apb_master_intf #(
        .ID_NUM  (4),
        .ADDR_W  (12),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .ACLK_i          (ACLK_i),
        .ARESETn_i       (ARESETn_i),
        .fifo_rvld_i     (fifo_rvld_i),
        .fifo_rrdy_o     (fifo_rrdy_o),
        .fifo_rpayload_i (fifo_rpayload_i),
        .PSEL_o          (PSEL_o),
        .PENABLE_o       (PENABLE_o),
        .PWRITE_o        (PWRITE_o),
        .PADDR_o         (PADDR_o),
        .PWDATA_o        (PWDATA_o),
        .PREADY_i        (PREADY_i),
        .PSLVERR_i       (PSLVERR_i),
        .rsp_vld_o       (rsp_vld_o),
        .rsp_rdy_i       (rsp_rdy_i),
        .rsp_payload_o   (rsp_payload_o)
    );

    always #5 ACLK_i = ~ACLK_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] cmd(input logic [3:0] id, input logic [11:0] addr,
                                        input logic [31:0] data);
        return {id, addr, data};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn_i       = 1'b0;
        fifo_rvld_i     = 1'b0;
        fifo_rpayload_i = '0;
        PREADY_i        = 1'b0;
        PSLVERR_i       = 1'b0;
        rsp_rdy_i       = 1'b1;

        // Reset values
        repeat (2) @(negedge ACLK_i);
        chk("rst_psel", PSEL_o, 0);
        chk("rst_penable", PENABLE_o, 0);
        chk("rst_pwrite", PWRITE_o, 0);
        chk("rst_rsp_vld", rsp_vld_o, 0);
        chk("rst_paddr", PADDR_o, 0);
        chk("rst_pwdata", PWDATA_o, 0);
        chk("rst_rsp_payload", rsp_payload_o, 0);
        ARESETn_i = 1'b1;
        #1 chk("rst_rrdy_released", fifo_rrdy_o, 1);

        // Single write, zero wait
        @(negedge ACLK_i);
        chk("t1_idle_psel", PSEL_o, 0);
        fifo_rvld_i     = 1'b1;
        fifo_rpayload_i = cmd(4'h3, 12'h104, 32'hDEADBEEF);
        PREADY_i        = 1'b1;
        @(negedge ACLK_i);
        chk("t1_setup_psel", PSEL_o, 1);
        chk("t1_setup_penable", PENABLE_o, 0);
        chk("t1_setup_pwrite", PWRITE_o, 1);
        chk("t1_setup_paddr", PADDR_o, 12'h104);
        chk("t1_setup_pwdata", PWDATA_o, 32'hDEADBEEF);
        chk("t1_setup_rrdy", fifo_rrdy_o, 0);
        fifo_rvld_i = 1'b0;
        @(negedge ACLK_i);
        chk("t1_access_psel", PSEL_o, 1);
        chk("t1_access_penable", PENABLE_o, 1);
        chk("t1_access_paddr", PADDR_o, 12'h104);
        chk("t1_access_pwdata", PWDATA_o, 32'hDEADBEEF);
        chk("t1_access_rsp_vld", rsp_vld_o, 0);
        @(negedge ACLK_i);
        chk("t1_resp_vld", rsp_vld_o, 1);
        chk("t1_resp_payload", rsp_payload_o, 5'h06);
        chk("t1_resp_psel", PSEL_o, 0);
        chk("t1_resp_penable", PENABLE_o, 0);
        @(negedge ACLK_i);
        chk("t1_idle_rsp_vld", rsp_vld_o, 0);
        chk("t1_idle_rrdy", fifo_rrdy_o, 1);
        chk("t1_idle_psel2", PSEL_o, 0);
        chk("t1_idle_paddr_hold", PADDR_o, 12'h104);
        chk("t1_idle_pwdata_hold", PWDATA_o, 32'hDEADBEEF);

        // Wait states, slave error, unaligned address
        fifo_rvld_i     = 1'b1;
        fifo_rpayload_i = cmd(4'h5, 12'h107, 32'h12345678);
        PREADY_i        = 1'b0;
        PSLVERR_i       = 1'b1;
        @(negedge ACLK_i);
        chk("t2_setup_psel", PSEL_o, 1);
        chk("t2_unaligned_paddr", PADDR_o, 12'h104);
        fifo_rvld_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK_i);
            chk("t2_access_penable", PENABLE_o, 1);
            chk("t2_access_paddr", PADDR_o, 12'h104);
            chk("t2_access_pwdata", PWDATA_o, 32'h12345678);
            chk("t2_access_rsp_vld", rsp_vld_o, 0);
            if (i == 3) PREADY_i = 1'b1;
        end
        @(negedge ACLK_i);
        chk("t2_resp_vld", rsp_vld_o, 1);
        chk("t2_resp_payload", rsp_payload_o, 5'h0B);
        chk("t2_resp_penable", PENABLE_o, 0);
        PREADY_i  = 1'b0;
        PSLVERR_i = 1'b0;
        @(negedge ACLK_i);
        chk("t2_idle_rsp_vld", rsp_vld_o, 0);

        // Timeout with PREADY stuck low
        fifo_rvld_i     = 1'b1;
        fifo_rpayload_i = cmd(4'h7, 12'h200, 32'hA5A5A5A5);
        @(negedge ACLK_i);
        chk("t3_setup_psel", PSEL_o, 1);
        fifo_rvld_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge ACLK_i);
            chk("t3_access_penable", PENABLE_o, 1);
        end
        @(negedge ACLK_i);
        chk("t3_timeout_rsp_vld", rsp_vld_o, 1);
        chk("t3_timeout_payload", rsp_payload_o, 5'h0F);
        chk("t3_timeout_psel", PSEL_o, 0);
        @(negedge ACLK_i);
        chk("t3_idle_rsp_vld", rsp_vld_o, 0);

        // PREADY arriving on the timeout cycle wins
        fifo_rvld_i     = 1'b1;
        fifo_rpayload_i = cmd(4'h2, 12'h300, 32'h0000_0001);
        PSLVERR_i       = 1'b1;
        @(negedge ACLK_i);
        fifo_rvld_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge ACLK_i);
            chk("t3b_access_penable", PENABLE_o, 1);
            if (i == 15) begin
                PREADY_i  = 1'b1;
                PSLVERR_i = 1'b0;
            end
        end
        @(negedge ACLK_i);
        chk("t3b_rsp_vld", rsp_vld_o, 1);
        chk("t3b_tie_payload", rsp_payload_o, 5'h04);
        @(negedge ACLK_i);
        chk("t3b_idle_rsp_vld", rsp_vld_o, 0);

        // Back-to-back, backpressure on the second response
        fifo_rvld_i     = 1'b1;
        fifo_rpayload_i = cmd(4'h0, 12'h040, 32'hC0DE0000);
        @(negedge ACLK_i);
        chk("t4_s0_paddr", PADDR_o, 12'h040);
        chk("t4_s0_rrdy", fifo_rrdy_o, 0);
        fifo_rpayload_i = cmd(4'h1, 12'h050, 32'hC0DE0001);
        @(negedge ACLK_i);
        chk("t4_a0_penable", PENABLE_o, 1);
        chk("t4_a0_pwdata", PWDATA_o, 32'hC0DE0000);
        @(negedge ACLK_i);
        chk("t4_r0_vld", rsp_vld_o, 1);
        chk("t4_r0_id", rsp_payload_o, 5'h00);
        chk("t4_r0_rrdy", fifo_rrdy_o, 1);
        @(negedge ACLK_i);
        chk("t4_s1_psel", PSEL_o, 1);
        chk("t4_s1_penable", PENABLE_o, 0);
        chk("t4_s1_paddr", PADDR_o, 12'h050);
        fifo_rpayload_i = cmd(4'h2, 12'h060, 32'hC0DE0002);
        @(negedge ACLK_i);
        chk("t4_a1_penable", PENABLE_o, 1);
        @(negedge ACLK_i);
        chk("t4_r1_vld", rsp_vld_o, 1);
        chk("t4_r1_id", rsp_payload_o, 5'h02);
        rsp_rdy_i = 1'b0;
        #1 chk("t4_r1_stall_rrdy", fifo_rrdy_o, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK_i);
            chk("t4_stall_vld", rsp_vld_o, 1);
            chk("t4_stall_payload", rsp_payload_o, 5'h02);
            chk("t4_stall_rrdy", fifo_rrdy_o, 0);
            chk("t4_stall_psel", PSEL_o, 0);
            chk("t4_stall_paddr", PADDR_o, 12'h050);
        end
        @(negedge ACLK_i);
        chk("t4_r1_release_payload", rsp_payload_o, 5'h02);
        rsp_rdy_i = 1'b1;
        #1 chk("t4_r1_release_rrdy", fifo_rrdy_o, 1);
        @(negedge ACLK_i);
        chk("t4_s2_paddr", PADDR_o, 12'h060);
        chk("t4_s2_rsp_vld", rsp_vld_o, 0);
        fifo_rpayload_i = cmd(4'h3, 12'h070, 32'hC0DE0003);
        @(negedge ACLK_i);
        @(negedge ACLK_i);
        chk("t4_r2_id", rsp_payload_o, 5'h04);
        @(negedge ACLK_i);
        chk("t4_s3_paddr", PADDR_o, 12'h070);
        fifo_rvld_i = 1'b0;
        @(negedge ACLK_i);
        chk("t4_a3_pwdata", PWDATA_o, 32'hC0DE0003);
        @(negedge ACLK_i);
        chk("t4_r3_vld", rsp_vld_o, 1);
        chk("t4_r3_id", rsp_payload_o, 5'h06);
        @(negedge ACLK_i);
        chk("t4_idle_rsp_vld", rsp_vld_o, 0);
        chk("t4_idle_rrdy", fifo_rrdy_o, 1);

        // Reset in the middle of ACCESS wait states
        fifo_rvld_i     = 1'b1;
        fifo_rpayload_i = cmd(4'h9, 12'h0A8, 32'h55AA55AA);
        PREADY_i        = 1'b0;
        @(negedge ACLK_i);
        fifo_rvld_i = 1'b0;
        repeat (2) @(negedge ACLK_i);
        chk("t5_pre_penable", PENABLE_o, 1);
        ARESETn_i = 1'b0;
        #1;
        chk("t5_rst_psel", PSEL_o, 0);
        chk("t5_rst_penable", PENABLE_o, 0);
        chk("t5_rst_pwrite", PWRITE_o, 0);
        chk("t5_rst_paddr", PADDR_o, 0);
        chk("t5_rst_pwdata", PWDATA_o, 0);
        chk("t5_rst_rsp_vld", rsp_vld_o, 0);
        chk("t5_rst_rsp_payload", rsp_payload_o, 0);
        chk("t5_rst_rrdy", fifo_rrdy_o, 0);
        @(negedge ACLK_i);
        ARESETn_i = 1'b1;
        #1 chk("t5_release_rrdy", fifo_rrdy_o, 1);
        PREADY_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK_i);
            chk("t5_after_rsp_vld", rsp_vld_o, 0);
            chk("t5_after_psel", PSEL_o, 0);
            chk("t5_after_rrdy", fifo_rrdy_o, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
